// File: rtl/xmtr_pkg.sv
// xmtr_pkg: WSI command codes, FSM states, FIFO entry layout
// and small helpers shared by the DIF transmit worker.
package xmtr_pkg;

   localparam logic [2:0] WSI_CMD_IDLE = 3'b000;
   localparam logic [2:0] WSI_CMD_WR   = 3'b001;

   typedef enum logic [2:0] {
      IDLE,
      LO,
      HI,
      GAP,
      DRAIN
   } state_t;

   typedef struct packed {
      logic        last;
      logic        info;
      logic [11:0] blen;
      logic [31:0] data;
   } entry_t;

   localparam int ENTRY_W = 46;

   // Word count to sample count; bit 11 falls off.
   function automatic logic [11:0] sample_len(
      input logic [11:0] words
   );
      return words << 1;
   endfunction

   function automatic logic [15:0] pick_half(
      input logic [31:0] d,
      input logic        hi
   );
      return hi ? d[31:16] : d[15:0];
   endfunction

endpackage

// File: rtl/xmtr_word_fifo.sv
// xmtr_word_fifo: show-ahead sync FIFO.
// Ports: clk/rst, push/wdata, pop/rdata, full, empty, count.
module xmtr_word_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 46,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr] <= wdata;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)
            rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(do_push)
                        - CW'(do_pop);
      end
   end

endmodule

// File: rtl/xmtr_worker_core.sv
// xmtr_worker_core: splits 32-bit WSI words from chan into
// two 16-bit samples on dif, keeping message boundaries.
// Ports: ctl_* clock/reset/enable; chan_* WSI slave in;
// dif_* WSI master out; stat_* saturating counters.
module xmtr_worker_core
   import xmtr_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int HIGH_FIRST = 0,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                 ctl_Clk,
   input  logic                 ctl_Reset,
   input  logic                 ctl_enable,
   input  logic [2:0]           chan_MCmd,
   input  logic                 chan_MReqLast,
   input  logic [11:0]          chan_MBurstLength,
   input  logic [31:0]          chan_MData,
   input  logic                 chan_MReqInfo,
   output logic                 chan_SThreadBusy,
   output logic [2:0]           dif_MCmd,
   output logic                 dif_MReqLast,
   output logic                 dif_MBurstPrecise,
   output logic [11:0]          dif_MBurstLength,
   output logic [15:0]          dif_MData,
   output logic                 dif_MReqInfo,
   input  logic                 dif_SThreadBusy,
   output logic [CNT_WIDTH-1:0] stat_msgs,
   output logic [CNT_WIDTH-1:0] stat_underrun
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CW-1:0] BUSY_AT =
      CW'(FIFO_DEPTH - 1);
   localparam bit HF = (HIGH_FIRST != 0);

   state_t        state_q;
   state_t        state_d;
   entry_t        wr_entry;
   entry_t        head;
   logic          f_full;
   logic          f_empty;
   logic [CW-1:0] f_count;
   logic [CW-1:0] occ_nxt;
   logic          push_ok;
   logic          pop;
   logic          issue;
   logic          msg_done;
   logic          underrun;
   logic          busy_d;
   logic          half_q;
   logic          first_q;
   logic [15:0]   sample;

   assign dif_MBurstPrecise = 1'b1;

   assign push_ok = (chan_MCmd == WSI_CMD_WR)
                 && !f_full;

   assign wr_entry = '{
      last: chan_MReqLast,
      info: chan_MReqInfo,
      blen: chan_MBurstLength,
      data: chan_MData
   };

   xmtr_word_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clk   (ctl_Clk),
      .rst   (ctl_Reset),
      .push  (push_ok),
      .wdata (wr_entry),
      .pop   (pop),
      .rdata (head),
      .full  (f_full),
      .empty (f_empty),
      .count (f_count)
   );

   // half_q = 0 before the first half of a word, 1 before
   // the second; it also carries position through DRAIN.
   assign sample = pick_half(head.data, half_q ^ HF);

   always_comb begin
      state_d  = state_q;
      issue    = 1'b0;
      pop      = 1'b0;
      msg_done = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (ctl_enable && !f_empty)
               state_d = LO;
         end
         LO: begin
            if (!ctl_enable) begin
               state_d = DRAIN;
            end else if (!dif_SThreadBusy) begin
               issue   = 1'b1;
               state_d = HI;
            end
         end
         HI: begin
            if (!ctl_enable) begin
               state_d = DRAIN;
            end else if (!dif_SThreadBusy) begin
               issue = 1'b1;
               pop   = 1'b1;
               if (head.last) begin
                  msg_done = 1'b1;
                  state_d  = IDLE;
               end else if (f_count > CW'(1)
                            || push_ok) begin
                  state_d = LO;
               end else begin
                  state_d = GAP;
               end
            end
         end
         GAP: begin
            if (!ctl_enable)
               state_d = DRAIN;
            else if (!f_empty)
               state_d = LO;
         end
         DRAIN: begin
            if (!f_empty && !dif_SThreadBusy) begin
               issue = 1'b1;
               if (half_q) begin
                  pop = 1'b1;
                  if (head.last) begin
                     msg_done = 1'b1;
                     state_d  = IDLE;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign occ_nxt = f_count + CW'(push_ok) - CW'(pop);

   // Asserting at DEPTH-1 leaves room for the one word
   // already in flight when upstream sees busy.
   assign busy_d = !ctl_enable
                || (state_d == DRAIN)
                || (occ_nxt >= BUSY_AT);

   assign underrun = (state_q == GAP) && f_empty
                  && !dif_SThreadBusy;

   always_ff @(posedge ctl_Clk) begin
      if (ctl_Reset) begin
         state_q          <= IDLE;
         half_q           <= 1'b0;
         first_q          <= 1'b1;
         chan_SThreadBusy <= 1'b1;
         dif_MCmd         <= WSI_CMD_IDLE;
         dif_MReqLast     <= 1'b0;
         dif_MData        <= '0;
         dif_MBurstLength <= '0;
         dif_MReqInfo     <= 1'b0;
         stat_msgs        <= '0;
         stat_underrun    <= '0;
      end else begin
         state_q          <= state_d;
         chan_SThreadBusy <= busy_d;
         dif_MCmd         <= issue ? WSI_CMD_WR
                                   : WSI_CMD_IDLE;
         dif_MReqLast     <= issue && half_q
                          && head.last;
         if (issue) begin
            dif_MData    <= sample;
            dif_MReqInfo <= head.info;
            half_q       <= !half_q;
            if (first_q)
               dif_MBurstLength <= sample_len(head.blen);
         end
         if (msg_done)
            first_q <= 1'b1;
         else if (issue)
            first_q <= 1'b0;
         if (msg_done && stat_msgs != '1)
            stat_msgs <= stat_msgs + 1'b1;
         if (underrun && stat_underrun != '1)
            stat_underrun <= stat_underrun + 1'b1;
      end
   end

endmodule
